// File: rtl/signed_div_sequencer_pkg.sv
// Shared definitions for the signed divide sequencer: state encoding, result
// fixup selector and the core handshake timeout.
package signed_div_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int BUSY_TIMEOUT  = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        FIX       = 3'd4,
        OUT       = 3'd5
    } state_t;

    // Selects which result the FIX state produces.
    typedef enum logic [1:0] {
        FIX_CORE     = 2'd0,
        FIX_DIV_ZERO = 2'd1,
        FIX_OVERFLOW = 2'd2
    } fix_kind_t;

endpackage

// File: rtl/signed_div_sequencer_twos_negate.sv
// Conditional two's-complement negate; used both to take operand magnitudes
// and to restore the sign of the core results.
module twos_negate
    import signed_div_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    // Wraps modulo 2^WIDTH, so the most negative value maps onto itself.
    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/signed_div_sequencer.sv
// Signed division front end: converts signed operands to magnitudes, drives an
// unsigned divider core, and restores signs with divide-by-zero/overflow shortcuts.
module signed_div_sequencer
    import signed_div_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             div_start,
    output logic             div_validated,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_ready,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MIN_VALUE = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           next_state;
    fix_kind_t        fix_kind;
    logic             sign_dividend;
    logic             sign_divisor;
    logic [WIDTH-1:0] dividend_lat;
    logic [WIDTH-1:0] core_q;
    logic [WIDTH-1:0] core_r;
    logic [2:0]       busy_cnt;
    logic [WIDTH-1:0] mag_dividend;
    logic [WIDTH-1:0] mag_divisor;
    logic [WIDTH-1:0] fixed_q;
    logic [WIDTH-1:0] fixed_r;
    logic             divisor_zero;
    logic             overflow_case;
    logic             busy_timeout;

    assign divisor_zero  = (divisor == '0);
    assign overflow_case = (dividend == MIN_VALUE) && (divisor == '1);
    assign busy_timeout  = (busy_cnt == 3'(BUSY_TIMEOUT - 1));

    twos_negate #(.WIDTH(WIDTH)) u_abs_dividend (
        .value  (dividend),
        .negate (dividend[WIDTH-1]),
        .result (mag_dividend)
    );

    twos_negate #(.WIDTH(WIDTH)) u_abs_divisor (
        .value  (divisor),
        .negate (divisor[WIDTH-1]),
        .result (mag_divisor)
    );

    twos_negate #(.WIDTH(WIDTH)) u_fix_quotient (
        .value  (core_q),
        .negate (sign_dividend ^ sign_divisor),
        .result (fixed_q)
    );

    twos_negate #(.WIDTH(WIDTH)) u_fix_remainder (
        .value  (core_r),
        .negate (sign_dividend),
        .result (fixed_r)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        next_state = state;
        in_ready   = (state == IDLE);
        out_valid  = (state == OUT);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (divisor_zero || overflow_case) next_state = FIX;
                    else                               next_state = LAUNCH;
                end
            end
            LAUNCH:    next_state = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!div_ready)        next_state = WAIT_DONE;
                else if (busy_timeout) next_state = FIX;
            end
            WAIT_DONE: if (div_ready) next_state = FIX;
            FIX:       next_state = OUT;
            OUT:       if (out_ready) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // NOTE: all datapath registers are reset so every output reads zero
    // during and after reset, not just the control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_start     <= 1'b0;
            div_validated <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            quotient      <= '0;
            remainder     <= '0;
            div_by_zero   <= 1'b0;
            overflow      <= 1'b0;
            fix_kind      <= FIX_CORE;
            sign_dividend <= 1'b0;
            sign_divisor  <= 1'b0;
            dividend_lat  <= '0;
            core_q        <= '0;
            core_r        <= '0;
            busy_cnt      <= '0;
        end else begin
            div_start <= (next_state == LAUNCH);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_dividend <= dividend[WIDTH-1];
                        sign_divisor  <= divisor[WIDTH-1];
                        dividend_lat  <= dividend;
                        div_dividend  <= mag_dividend;
                        div_divisor   <= mag_divisor;
                        div_validated <= !divisor_zero;
                        if (divisor_zero)       fix_kind <= FIX_DIV_ZERO;
                        else if (overflow_case) fix_kind <= FIX_OVERFLOW;
                        else                    fix_kind <= FIX_CORE;
                    end
                end
                LAUNCH: busy_cnt <= '0;
                WAIT_BUSY: begin
                    // A core that never leaves idle is treated as having rejected the operands.
                    if (div_ready) begin
                        if (busy_timeout) fix_kind <= FIX_DIV_ZERO;
                        else              busy_cnt <= busy_cnt + 3'd1;
                    end
                end
                WAIT_DONE: begin
                    if (div_ready) begin
                        core_q <= div_quotient;
                        core_r <= div_remainder;
                    end
                end
                FIX: begin
                    case (fix_kind)
                        FIX_DIV_ZERO: begin
                            quotient    <= '1;
                            remainder   <= dividend_lat;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end
                        FIX_OVERFLOW: begin
                            quotient    <= MIN_VALUE;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                        end
                        default: begin
                            quotient    <= fixed_q;
                            remainder   <= fixed_r;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_div_sequencer.sv
// Directed bench for signed_div_sequencer; the bench itself plays the divider core.
module tb_signed_div_sequencer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             div_start;
    logic             div_validated;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic             div_ready;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    logic [36:0] all_outs;
    int checks = 0;
    int errors = 0;

    assign all_outs = {div_start, div_validated, div_dividend, div_divisor, out_valid,
                       quotient, remainder, div_by_zero, overflow};

    always #5 clk = ~clk;

    signed_div_sequencer #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .dividend      (dividend),
        .divisor       (divisor),
        .div_start     (div_start),
        .div_validated (div_validated),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_ready     (div_ready),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .quotient      (quotient),
        .remainder     (remainder),
        .div_by_zero   (div_by_zero),
        .overflow      (overflow)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick();
        tick();
        checks++;
        if (all_outs !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (all_outs !== 37'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: got outs=%h in_ready=%b expected 0/1", all_outs, in_ready);
        end
    endtask

    // Full core transaction: launch, busy for a few cycles, done, sign fixup.
    task automatic test_core_divide(input string name,
                                    input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dsr,
                                    input logic [WIDTH-1:0] mag_a, input logic [WIDTH-1:0] mag_b,
                                    input logic [WIDTH-1:0] core_q, input logic [WIDTH-1:0] core_r,
                                    input logic [WIDTH-1:0] exp_q, input logic [WIDTH-1:0] exp_r);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready: got %b expected 1", name, in_ready);
        end
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dsr;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({div_start, div_validated, div_dividend, div_divisor} !== {1'b1, 1'b1, mag_a, mag_b}) begin
            errors++;
            $display("FAIL %s launch: got start=%b valid=%b a=%h b=%h expected 1 1 %h %h",
                     name, div_start, div_validated, div_dividend, div_divisor, mag_a, mag_b);
        end
        tick();
        checks++;
        if (div_start !== 1'b0) begin
            errors++;
            $display("FAIL %s start_width: got %b expected 0", name, div_start);
        end
        div_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({out_valid, div_start, div_dividend, div_divisor} !== {1'b0, 1'b0, mag_a, mag_b}) begin
                errors++;
                $display("FAIL %s busy_%0d: got ov=%b start=%b a=%h b=%h expected 0 0 %h %h",
                         name, i, out_valid, div_start, div_dividend, div_divisor, mag_a, mag_b);
            end
        end
        div_ready     = 1'b1;
        div_quotient  = core_q;
        div_remainder = core_r;
        tick();
        div_quotient  = 8'hAA;
        div_remainder = 8'h55;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s fix_cycle: got out_valid=%b expected 0", name, out_valid);
        end
        tick();
        checks++;
        if ({out_valid, in_ready, quotient, remainder, div_by_zero, overflow} !==
            {1'b1, 1'b0, exp_q, exp_r, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s result: got ov=%b ir=%b q=%h r=%h dbz=%b ovf=%b expected 1 0 %h %h 0 0",
                     name, out_valid, in_ready, quotient, remainder, div_by_zero, overflow, exp_q, exp_r);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL %s return_idle: got ir=%b ov=%b expected 1 0", name, in_ready, out_valid);
        end
    endtask

    // Divide-by-zero and overflow bypass the core entirely.
    task automatic test_shortcut(input string name,
                                 input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dsr,
                                 input logic [WIDTH-1:0] exp_q, input logic [WIDTH-1:0] exp_r,
                                 input logic exp_dbz, input logic exp_ovf);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dsr;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, div_start} !== 2'b00) begin
            errors++;
            $display("FAIL %s fix_cycle: got ov=%b start=%b expected 0 0", name, out_valid, div_start);
        end
        tick();
        checks++;
        if ({out_valid, div_start, quotient, remainder, div_by_zero, overflow} !==
            {1'b1, 1'b0, exp_q, exp_r, exp_dbz, exp_ovf}) begin
            errors++;
            $display("FAIL %s result: got ov=%b start=%b q=%h r=%h dbz=%b ovf=%b expected 1 0 %h %h %b %b",
                     name, out_valid, div_start, quotient, remainder, div_by_zero, overflow,
                     exp_q, exp_r, exp_dbz, exp_ovf);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL %s return_idle: got ir=%b ov=%b expected 1 0", name, in_ready, out_valid);
        end
    endtask

    // -7 / 0 held in OUT for 5 cycles while in_valid is pulsed with a new pair.
    task automatic test_backpressure;
        in_valid = 1'b1;
        dividend = 8'hF9;
        divisor  = 8'h00;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            dividend = 8'd100;
            divisor  = 8'd7;
            checks++;
            if ({out_valid, in_ready, quotient, remainder, div_by_zero, overflow} !==
                {1'b1, 1'b0, 8'hFF, 8'hF9, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL backpressure_%0d: got ov=%b ir=%b q=%h r=%h dbz=%b ovf=%b expected 1 0 ff f9 1 0",
                         i, out_valid, in_ready, quotient, remainder, div_by_zero, overflow);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL backpressure_release: got ir=%b ov=%b expected 1 0", in_ready, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({in_ready, out_valid, div_start} !== 3'b100) begin
                errors++;
                $display("FAIL backpressure_no_accept_%0d: got ir=%b ov=%b start=%b expected 1 0 0",
                         i, in_ready, out_valid, div_start);
            end
        end
    endtask

    // Core never drops div_ready: four WAIT_BUSY cycles, then a div_by_zero result.
    task automatic test_core_timeout;
        in_valid = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        tick();
        in_valid = 1'b0;
        checks++;
        if (div_start !== 1'b1) begin
            errors++;
            $display("FAIL timeout_launch: got start=%b expected 1", div_start);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait_%0d: got out_valid=%b expected 0", i, out_valid);
            end
        end
        tick();
        checks++;
        if ({out_valid, div_by_zero, overflow} !== 3'b110) begin
            errors++;
            $display("FAIL timeout_result: got ov=%b dbz=%b ovf=%b expected 1 1 0",
                     out_valid, div_by_zero, overflow);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Reset while the core is busy; its late result must be ignored.
    task automatic test_reset_mid_divide;
        in_valid = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        tick();
        in_valid = 1'b0;
        tick();
        div_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (all_outs !== 37'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_async: got outs=%h ir=%b expected 0 1", all_outs, in_ready);
        end
        tick();
        div_ready     = 1'b1;
        div_quotient  = 8'd14;
        div_remainder = 8'd2;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (all_outs !== 37'd0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_reset_ignore_%0d: got outs=%h ir=%b expected 0 1", i, all_outs, in_ready);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        dividend      = '0;
        divisor       = '0;
        div_ready     = 1'b1;
        div_quotient  = '0;
        div_remainder = '0;
        out_ready     = 1'b0;

        test_reset();
        test_core_divide("pos_div", 8'd100, 8'd7, 8'd100, 8'd7, 8'd14, 8'd2, 8'd14, 8'd2);
        test_core_divide("neg_dividend", 8'h9C, 8'd7, 8'd100, 8'd7, 8'd14, 8'd2, 8'hF2, 8'hFE);
        test_shortcut("div_zero", 8'd25, 8'd0, 8'hFF, 8'd25, 1'b1, 1'b0);
        test_shortcut("overflow", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
        test_backpressure();
        test_core_timeout();
        test_reset_mid_divide();
        test_core_divide("neg_divisor", 8'd9, 8'hFD, 8'd9, 8'd3, 8'd3, 8'd0, 8'hFD, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_div_sequencer.md
SIGNED_DIV_SEQUENCER -- requirements
Module: signed_div_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 4..16.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand pair presented.
REQ-005 in_ready  output  1  sequencer can accept an operand pair.
REQ-006 dividend  input  WIDTH  signed two's-complement dividend.
REQ-007 divisor  input  WIDTH  signed two's-complement divisor.
REQ-008 div_start  output  1  one-cycle start pulse to the unsigned non-restoring divider core.
REQ-009 div_validated  output  1  operands-valid qualifier to the core; high when the latched divisor is nonzero.
REQ-010 div_dividend, div_divisor  output  WIDTH each  unsigned magnitudes driven to the core.
REQ-011 div_ready  input  1  core idle/done; high in the core idle state, low while the core is busy.
REQ-012 div_quotient, div_remainder  input  WIDTH each  unsigned core results; valid when div_ready rises.
REQ-013 out_valid  output  1  result held for the consumer.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 quotient, remainder  output  WIDTH each  signed results.
REQ-016 div_by_zero, overflow  output  1 each  result status flags; valid with out_valid.

Function
REQ-017 States SHALL be IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, FIX, OUT.
REQ-018 IDLE: in_ready=1; on in_valid, the sequencer SHALL latch both operands and their sign bits, then move as follows: divisor==0 goes to FIX; dividend==-2^(WIDTH-1) with divisor==-1 goes to FIX; all other operands go to LAUNCH.
REQ-019 Magnitudes SHALL be registered at accept: abs(x) as an unsigned WIDTH-bit value. abs(-2^(WIDTH-1)) SHALL equal 2^(WIDTH-1).
REQ-020 LAUNCH: div_start=1 for exactly one cycle, then go to WAIT_BUSY; div_dividend, div_divisor and div_validated SHALL stay stable from LAUNCH until the core's done cycle.
REQ-021 WAIT_BUSY: stay while div_ready=1, for at most 4 cycles; on div_ready=0 go to WAIT_DONE. If div_ready stays high for 4 cycles, go to FIX with div_by_zero=1, treating the core as having rejected the operands.
REQ-022 WAIT_DONE: stay while div_ready=0; on div_ready=1, capture div_quotient and div_remainder in the same cycle and go to FIX.
REQ-023 FIX (one cycle): compute signed results and go to OUT.
- quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend) (truncating division).
- Negation is two's complement, modulo 2^WIDTH.
REQ-024 Divide-by-zero: quotient = all ones, remainder = dividend, div_by_zero=1, overflow=0.
REQ-025 Overflow case (-2^(WIDTH-1) / -1): quotient = -2^(WIDTH-1), remainder = 0, overflow=1, div_by_zero=0.
REQ-026 OUT: out_valid=1; quotient, remainder and flags SHALL be held stable until out_ready=1, then go to IDLE; in_ready stays 0 while in OUT.
REQ-027 in_valid SHALL be ignored in every state other than IDLE; no operand pair is dropped or duplicated.
REQ-028 Latency: shortcut paths (REQ-024/025) give out_valid 2 cycles after the accept edge; core path gives out_valid 2 cycles after the div_ready rising edge.
REQ-029 All outputs SHALL be registered except in_ready and out_valid, which are decoded from the state register.

Reset
REQ-030 rst SHALL force IDLE at any time, including mid-divide.
REQ-031 During and after rst, every output except in_ready SHALL be 0: div_start, div_validated, div_dividend, div_divisor, out_valid, quotient, remainder, div_by_zero, overflow. in_ready=1 after rst deasserts.
REQ-032 A core result arriving after a mid-operation reset SHALL be ignored; capture happens only in WAIT_DONE.

Structure
REQ-033 A shared package SHALL hold the state encoding (3-bit, IDLE=0), the WIDTH default and the WAIT_BUSY timeout constant 4.
REQ-034 One sub-module, twos_negate (conditional two's-complement negate, WIDTH-parameterised), SHALL be instantiated for magnitude generation and result fixup.

Verification
REQ-035 WIDTH=8: 100 / 7, core returns q=14, r=2 -> quotient=14, remainder=2, flags 0.
REQ-036 -100 / 7, core receives 100/7 and returns 14, 2 -> quotient=-14 (0xF2), remainder=-2 (0xFE).
REQ-037 25 / 0 -> div_start never pulses; quotient=0xFF, remainder=25, div_by_zero=1, out_valid 2 cycles after accept.
REQ-038 -128 / -1 -> no core launch; quotient=0x80, remainder=0, overflow=1.
REQ-039 Backpressure: out_ready held low 5 cycles -> outputs stable; in_valid pulses during OUT are not accepted; release -> IDLE, in_ready=1.
REQ-040 rst asserted in WAIT_DONE, then core raises div_ready -> no out_valid, all outputs 0; next 9 / -3 -> quotient=-3 (0xFD), remainder=0.
